// File: rtl/rsa_modexp_ladder_if.sv
// Request/response bundle for the modular exponentiation engine.
// The engine takes the slave side; whoever issues operations takes the master side.
interface rsa_modexp_ladder_if #(
    parameter int WIDTH     = 16,
    parameter int EXP_WIDTH = 16,
    parameter int CNT_WIDTH = 24
) ();
    logic                 start;
    logic                 mode;
    logic [WIDTH-1:0]     base;
    logic [EXP_WIDTH-1:0] exp;
    logic [WIDTH-1:0]     mod;
    logic [WIDTH-1:0]     result;
    logic                 busy;
    logic                 done;
    logic                 err;
    logic [CNT_WIDTH-1:0] cycle_count;

    modport master (
        output start, mode, base, exp, mod,
        input  result, busy, done, err, cycle_count
    );

    modport slave (
        input  start, mode, base, exp, mod,
        output result, busy, done, err, cycle_count
    );
endinterface

// File: rtl/rsa_modexp_ladder.sv
// Modular exponentiation (base^exp mod n) on one shared bit-serial interleaved multiplier,
// selectable between square-and-multiply and a constant-time Montgomery ladder.
module rsa_modexp_ladder #(
    parameter int WIDTH     = 16,
    parameter int EXP_WIDTH = 16,
    parameter int CNT_WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    rsa_modexp_ladder_if.slave   bus
);

    localparam int CYW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int BIW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        REDUCE,
        MUL,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic                 mode_q, mode_d;
    logic [EXP_WIDTH-1:0] exp_q, exp_d;
    logic [WIDTH-1:0]     n_q, n_d;
    logic [WIDTH-1:0]     bpr_q, bpr_d;
    logic [WIDTH-1:0]     r0_q, r0_d;
    logic [WIDTH-1:0]     r1_q, r1_d;
    logic [WIDTH:0]       acc_q, acc_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [CYW-1:0]       cyc_q, cyc_d;
    logic [BIW-1:0]       bit_q, bit_d;
    logic                 phase_q, phase_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 err_q, err_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic [WIDTH:0]       dbl, dblRed, addv, addRed, stepAcc;
    logic [WIDTH-1:0]     prod;
    logic                 curBit, lastOfBit, writeR0;

    // Which ladder register receives the product of the current multiply.
    function automatic logic destIsR0(input logic m, input logic bitv, input logic ph);
        if (!m) return 1'b1;
        return ph ? ~bitv : bitv;
    endfunction

    // Operands {a, b} for the multiply identified by (mode, exponent bit, phase).
    // In ladder mode both multiplies of a bit read pre-bit values, which holds because
    // the first multiply never overwrites the register the second one reads.
    function automatic logic [2*WIDTH-1:0] nextOperands(
        input logic             m,
        input logic             bitv,
        input logic             ph,
        input logic [WIDTH-1:0] r0,
        input logic [WIDTH-1:0] r1,
        input logic [WIDTH-1:0] bp
    );
        if (!m) return ph ? {r0, bp} : {r0, r0};
        if (!ph) return {r0, r1};
        return bitv ? {r1, r1} : {r0, r0};
    endfunction

    // One interleaved step: double, reduce, conditionally add b, reduce. acc < n keeps
    // every intermediate below 2n, which fits WIDTH+1 bits even for n = 2^WIDTH-1.
    always_comb begin
        dbl     = acc_q << 1;
        dblRed  = (dbl >= {1'b0, n_q}) ? dbl - {1'b0, n_q} : dbl;
        addv    = dblRed + {1'b0, b_q};
        addRed  = (addv >= {1'b0, n_q}) ? addv - {1'b0, n_q} : addv;
        stepAcc = a_q[WIDTH-1] ? addRed : dblRed;
        prod    = stepAcc[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            mode_q   <= 1'b0;
            exp_q    <= '0;
            n_q      <= '0;
            bpr_q    <= '0;
            r0_q     <= '0;
            r1_q     <= '0;
            acc_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cyc_q    <= '0;
            bit_q    <= '0;
            phase_q  <= 1'b0;
            result_q <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            exp_q    <= exp_d;
            n_q      <= n_d;
            bpr_q    <= bpr_d;
            r0_q     <= r0_d;
            r1_q     <= r1_d;
            acc_q    <= acc_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cyc_q    <= cyc_d;
            bit_q    <= bit_d;
            phase_q  <= phase_d;
            result_q <= result_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        exp_d     = exp_q;
        n_d       = n_q;
        bpr_d     = bpr_q;
        r0_d      = r0_q;
        r1_d      = r1_q;
        acc_d     = acc_q;
        a_d       = a_q;
        b_d       = b_q;
        cyc_d     = cyc_q;
        bit_d     = bit_q;
        phase_d   = phase_q;
        result_d  = result_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        curBit    = exp_q[bit_q];
        lastOfBit = 1'b0;
        writeR0   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    mode_d   = bus.mode;
                    exp_d    = bus.exp;
                    n_d      = bus.mod;
                    err_d    = (bus.mod == '0);
                    cnt_d    = '0;
                    result_d = '0;
                    acc_d    = '0;
                    a_d      = bus.base;
                    b_d      = WIDTH'(1);
                    cyc_d    = '0;
                    bit_d    = BIW'(EXP_WIDTH - 1);
                    phase_d  = 1'b0;
                    state_d  = (bus.mod == '0) ? DONE : REDUCE;
                end
            end

            REDUCE, MUL: begin
                acc_d = stepAcc;
                a_d   = a_q << 1;
                cyc_d = cyc_q + CYW'(1);
                cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);
                if (cyc_q == CYW'(WIDTH - 1)) begin
                    cyc_d = '0;
                    acc_d = '0;
                    if (state_q == REDUCE) begin
                        bpr_d   = prod;
                        r1_d    = prod;
                        r0_d    = (n_q == WIDTH'(1)) ? '0 : WIDTH'(1);
                        state_d = MUL;
                    end else begin
                        writeR0 = destIsR0(mode_q, curBit, phase_q);
                        if (writeR0) r0_d = prod;
                        else         r1_d = prod;
                        // Square-and-multiply skips the second multiply on a zero bit.
                        lastOfBit = mode_q ? phase_q : (phase_q | ~curBit);
                        if (!lastOfBit) begin
                            phase_d = 1'b1;
                        end else if (bit_q == '0) begin
                            state_d  = DONE;
                            result_d = r0_d;
                        end else begin
                            bit_d   = bit_q - BIW'(1);
                            phase_d = 1'b0;
                        end
                    end
                    {a_d, b_d} = nextOperands(mode_q, exp_q[bit_d], phase_d, r0_d, r1_d, bpr_d);
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.result      = result_q;
    assign bus.busy        = (state_q == REDUCE) || (state_q == MUL);
    assign bus.done        = (state_q == DONE);
    assign bus.err         = err_q;
    assign bus.cycle_count = cnt_q;

endmodule

// File: doc/rsa_modexp_ladder.md
Name: rsa_modexp_ladder

Overview:
Parametrised modular exponentiation engine (result = base^exp mod mod) for the RSA encrypt/decrypt datapath. It generalises the fixed-width encrypt/decrypt blocks in two ways: parametrised widths, and a run-time mode that selects leaky square-and-multiply or constant-time Montgomery ladder. It reports its own busy-cycle count so the timing side channel can be measured on-chip. A single bit-serial interleaved modular multiplier is shared by all steps.

Parameters:
WIDTH, 16, modulus/base/result width in bits
EXP_WIDTH, 16, exponent width; all EXP_WIDTH bits are always scanned, MSB first
CNT_WIDTH, 24, width of cycle_count

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
mode  input  1  0 = square-and-multiply (data-dependent timing); 1 = Montgomery ladder (constant time)
base  input  WIDTH  message/ciphertext; any value, reduced internally
exp  input  EXP_WIDTH  exponent (e or d)
mod  input  WIDTH  modulus n
result  output  WIDTH  base^exp mod n; valid with done, held until next accepted start
busy  output  1  high while computing
done  output  1  one-cycle completion pulse
err  output  1  set with done when mod==0; held until next accepted start
cycle_count  output  CNT_WIDTH  busy cycles of last operation; held until next accepted start

Behaviour:
- Reset (sync, rst=1 at a clk edge): state IDLE; result, busy, done, err and cycle_count all 0. Reset mid-operation aborts immediately, with no done pulse.
- Accept: at cycle T, in IDLE with start=1, latch base, exp, mod and mode; clear err and cycle_count. start is ignored while busy or in the done cycle.
- States: IDLE -> REDUCE -> SCAN/MUL (per exponent bit) -> DONE -> IDLE. mod==0 takes IDLE -> DONE directly, with err=1, result=0, cycle_count=0, done at T+1.
- Modmul(a,b): interleaved, exactly WIDTH cycles, one multiplier bit per cycle, a scanned MSB first.
  - acc = 2*acc, minus n if acc >= n.
  - If the a bit is 1: acc = acc + b, minus n if acc >= n.
  - acc is WIDTH+1 bits internally. Requires b < n; a is unrestricted.
- REDUCE: b' = modmul(base, 1), i.e. base mod n (WIDTH cycles).
- Initial values: R0 = (n==1 ? 0 : 1). Mode 1 also sets R1 = b'.
- Mode 0, per bit i from EXP_WIDTH-1 down to 0:
  - R0 = R0*R0.
  - If exp[i]=1: R0 = R0*b'.
  - Leading zeros are not skipped.
- Mode 1, per bit i:
  - exp[i]=1: R0 = R0*R1, then R1 = R1*R1.
  - exp[i]=0: R1 = R0*R1, then R0 = R0*R0.
  - The operands for both multiplies are taken from pre-bit values.
  - Exactly 2 modmuls per bit.
- Modmul count M:
  - Mode 0: M = EXP_WIDTH + popcount(exp).
  - Mode 1: M = 2*EXP_WIDTH.
- Latency:
  - busy is high for cycles T+1 .. T+WIDTH*(1+M).
  - DONE is cycle T+WIDTH*(1+M)+1: done=1, busy=0, result=R0, cycle_count=WIDTH*(1+M). The counter saturates at all-ones.
  - The next start can be accepted in the cycle after done.
- Boundaries:
  - exp==0 gives result 1 (0 if n==1).
  - base >= n is handled by REDUCE.
  - n==1 gives result 0 with normal timing.
  - The maximum n = 2^WIDTH-1 must not overflow acc.

Test Plan:
- Mode 0, base=65, exp=17, mod=3233 -> result=2790; popcount 2 gives M=18, cycle_count=304; done exactly at T+305.
- Mode 1, same operands -> result=2790, cycle_count=528, done at T+529; mode 1 with exp=2753 on base=2790 -> result=65, cycle_count=528 (identical timing).
- Mode 0, base=2790, exp=2753, mod=3233 -> result=65; popcount 5 gives cycle_count=352. Also base=3298 (>= mod), exp=17 -> 2790.
- Edge operands: exp=0, mod=3233 -> result=1. mod=1 -> result=0, normal timing. mod=0 -> err=1, done at T+1, result=0, cycle_count=0.
- Protocol: assert start with new operands mid-operation -> ignored, and the first operation's result and timing are unchanged. Hold start high through done -> a new operation is accepted the cycle after done.
- Assert rst for one cycle mid-operation -> all outputs 0 next cycle, no done pulse; a subsequent start completes correctly.
